// File: rtl/mem_pkg.sv
// Shared definitions for the line-refill path: line geometry helpers and the
// refill arbiter state encoding.
package mem_pkg;

  localparam int DEF_NUM_BLOCKS = 4;
  localparam int DEF_BLOCK_SIZE = 4;

  function automatic int line_width(input int num_blocks, input int block_size);
    return 8 * num_blocks * block_size;
  endfunction

  function automatic int line_lob(input int num_blocks, input int block_size);
    return $clog2(num_blocks * block_size);
  endfunction

  localparam int LINE_W = line_width(DEF_NUM_BLOCKS, DEF_BLOCK_SIZE);
  localparam int LOB    = line_lob(DEF_NUM_BLOCKS, DEF_BLOCK_SIZE);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/mem_refill_arb_rr_arb2.sv
// Two-way round-robin picker: when both request, the one not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  assign gnt_id = (&req) ? ~last : req[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
    assign gnt[gi] = req[gi] && (gnt_id == 1'(gi));
  end

endmodule

// File: rtl/mem_refill_arb.sv
// Shares one line-refill memory port between two requesters: round-robin grant,
// single outstanding line fetch, abort tracking and a sticky WAIT watchdog.
module mem_refill_arb
  import mem_pkg::*;
#(
  parameter int NUM_BLOCKS = 4,
  parameter int BLOCK_SIZE = 4,
  parameter int TIMEOUT    = 1024,
  localparam int LINE_BITS = line_width(NUM_BLOCKS, BLOCK_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [31:0]          req0_addr,
  output logic                 req0_ready,
  output logic [LINE_BITS-1:0] req0_rdata,
  input  logic                 req1_valid,
  input  logic [31:0]          req1_addr,
  output logic                 req1_ready,
  output logic [LINE_BITS-1:0] req1_rdata,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [31:0]          mem_req_addr,
  input  logic [LINE_BITS-1:0] mem_req_rdata,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int OFF_BITS = line_lob(NUM_BLOCKS, BLOCK_SIZE);
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFF_BITS) - 32'd1);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             rr_last_q, rr_last_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tout_q, tout_d;
  logic             mvalid_q, mvalid_d;
  logic [31:0]      maddr_q, maddr_d;

  logic [1:0]  req_valid;
  logic [31:0] req_addr [2];
  logic [1:0]  pick_gnt;
  logic        pick_id;
  logic        abort_now;
  logic        deliver;

  assign req_valid   = {req1_valid, req0_valid};
  assign req_addr[0] = req0_addr;
  assign req_addr[1] = req1_addr;

  rr_arb2 u_rr (
    .req    (req_valid),
    .last   (rr_last_q),
    .gnt    (pick_gnt),
    .gnt_id (pick_id)
  );

  // A requester that lets go of valid mid-fetch has its line discarded on return.
  assign abort_now = abort_q | ~req_valid[gnt_q];
  assign deliver   = (state_q == ST_WAIT) && mem_req_ready && !abort_now;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_last_d = rr_last_q;
    abort_d   = abort_q;
    cnt_d     = cnt_q;
    tout_d    = tout_q;
    mvalid_d  = mvalid_q;
    maddr_d   = maddr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|pick_gnt) begin
          gnt_d     = pick_id;
          rr_last_d = pick_id;
          maddr_d   = req_addr[pick_id] & ALIGN_MASK;
          mvalid_d  = 1'b1;
          abort_d   = 1'b0;
          cnt_d     = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        abort_d = abort_now;
        if (mem_req_ready) begin
          mvalid_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_RESP;
        end else if (TIMEOUT != 0 && cnt_q != CNT_MAX) begin
          // Counter saturates at the limit so the flag stays meaningful.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_MAX) tout_d = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      rr_last_q <= 1'b1;
      abort_q   <= 1'b0;
      cnt_q     <= '0;
      tout_q    <= 1'b0;
      mvalid_q  <= 1'b0;
      maddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_last_q <= rr_last_d;
      abort_q   <= abort_d;
      cnt_q     <= cnt_d;
      tout_q    <= tout_d;
      mvalid_q  <= mvalid_d;
      maddr_q   <= maddr_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic                 ready_q;
    logic [LINE_BITS-1:0] rdata_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        ready_q <= 1'b0;
        rdata_q <= '0;
      end else begin
        ready_q <= deliver && (gnt_q == 1'(gi));
        if (deliver && (gnt_q == 1'(gi))) rdata_q <= mem_req_rdata;
      end
    end
  end

  assign req0_ready    = g_chan[0].ready_q;
  assign req0_rdata    = g_chan[0].rdata_q;
  assign req1_ready    = g_chan[1].ready_q;
  assign req1_rdata    = g_chan[1].rdata_q;
  assign mem_req_valid = mvalid_q;
  assign mem_req_addr  = maddr_q;
  assign busy          = (state_q != ST_IDLE);
  assign timeout_err   = tout_q;

endmodule
